// File: rtl/maxpool_layer.sv
// Per-channel signed max-pooling over POOL_SIZE consecutive rows, frame-aware,
// with optional ReLU and a single registered output stage (valid/ready both sides).
module maxpool_layer #(
  parameter int INPUT_LAYER_HEIGHT = 4,
  parameter int POOL_SIZE          = 2,
  parameter int N_CHANNELS         = 1,
  parameter int WORD_SIZE          = 16,
  parameter bit RELU               = 1'b1
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic                             valid_i,
  output logic                             ready_o,
  input  logic [N_CHANNELS*WORD_SIZE-1:0]  data_i,
  output logic                             valid_o,
  input  logic                             ready_i,
  output logic [N_CHANNELS*WORD_SIZE-1:0]  data_o,
  output logic                             last_o
);

  localparam int RW = (INPUT_LAYER_HEIGHT > 1) ? $clog2(INPUT_LAYER_HEIGHT) : 1;
  localparam int WW = (POOL_SIZE > 1) ? $clog2(POOL_SIZE) : 1;
  localparam logic [RW-1:0] ROW_LAST = RW'(INPUT_LAYER_HEIGHT - 1);
  localparam logic [WW-1:0] WIN_LAST = WW'(POOL_SIZE - 1);
  localparam int DW = N_CHANNELS * WORD_SIZE;

  typedef enum logic {eEMPTY, eACC} state_t;

  state_t          state;
  logic [RW-1:0]   row_cnt;
  logic [WW-1:0]   win_cnt;
  logic [DW-1:0]   acc;
  logic [DW-1:0]   max_v;
  logic [DW-1:0]   result;
  logic [DW-1:0]   relu_v;
  logic            row_end;
  logic            closing;
  logic            in_fire;
  logic            out_fire;

  assign row_end  = (row_cnt == ROW_LAST);
  assign closing  = (win_cnt == WIN_LAST) || row_end;
  // Only a closing row can overflow the single output register; never looks at valid_i.
  assign ready_o  = !(closing && valid_o && !ready_i);
  assign in_fire  = valid_i && ready_o;
  assign out_fire = valid_o && ready_i;

  always_comb begin
    max_v  = '0;
    relu_v = '0;
    for (int unsigned c = 0; c < N_CHANNELS; c++) begin
      if ($signed(acc[c*WORD_SIZE +: WORD_SIZE]) > $signed(data_i[c*WORD_SIZE +: WORD_SIZE]))
        max_v[c*WORD_SIZE +: WORD_SIZE] = acc[c*WORD_SIZE +: WORD_SIZE];
      else
        max_v[c*WORD_SIZE +: WORD_SIZE] = data_i[c*WORD_SIZE +: WORD_SIZE];
    end
    result = (state == eACC) ? max_v : data_i;
    for (int unsigned c = 0; c < N_CHANNELS; c++) begin
      if (RELU && result[c*WORD_SIZE + WORD_SIZE - 1])
        relu_v[c*WORD_SIZE +: WORD_SIZE] = '0;
      else
        relu_v[c*WORD_SIZE +: WORD_SIZE] = result[c*WORD_SIZE +: WORD_SIZE];
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state   <= eEMPTY;
      row_cnt <= '0;
      win_cnt <= '0;
      acc     <= '0;
      valid_o <= 1'b0;
      last_o  <= 1'b0;
      data_o  <= '0;
    end else begin
      if (in_fire) begin
        // acc and the closing result share one datapath: first row of a window loads data_i.
        acc     <= result;
        win_cnt <= closing ? '0 : win_cnt + 1'b1;
        row_cnt <= row_end ? '0 : row_cnt + 1'b1;
        if (closing) begin
          state   <= eEMPTY;
          data_o  <= relu_v;
          valid_o <= 1'b1;
          last_o  <= row_end;
        end else begin
          state   <= eACC;
        end
      end
      if (out_fire && !(in_fire && closing)) begin
        valid_o <= 1'b0;
        last_o  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_maxpool_layer.sv
// Bench for maxpool_layer: default instance (H=4,P=2,N=1,RELU=1) and a second
// instance (H=5,P=2,N=2,RELU=0) driven one at a time against a queue-based model.
module tb_maxpool_layer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        a_valid, a_rdy, a_ready_o, a_valid_o, a_last_o;
  logic [15:0] a_data, a_data_o;
  logic        b_valid, b_rdy, b_ready_o, b_valid_o, b_last_o;
  logic [31:0] b_data, b_data_o;

  always #5 clk = ~clk;

  maxpool_layer #(
    .INPUT_LAYER_HEIGHT(4), .POOL_SIZE(2), .N_CHANNELS(1), .WORD_SIZE(16), .RELU(1'b1)
  ) u_dut_a (
    .clk_i(clk), .reset_n_i(reset_n), .valid_i(a_valid), .ready_o(a_ready_o),
    .data_i(a_data), .valid_o(a_valid_o), .ready_i(a_rdy), .data_o(a_data_o), .last_o(a_last_o)
  );

  maxpool_layer #(
    .INPUT_LAYER_HEIGHT(5), .POOL_SIZE(2), .N_CHANNELS(2), .WORD_SIZE(16), .RELU(1'b0)
  ) u_dut_b (
    .clk_i(clk), .reset_n_i(reset_n), .valid_i(b_valid), .ready_o(b_ready_o),
    .data_i(b_data), .valid_o(b_valid_o), .ready_i(b_rdy), .data_o(b_data_o), .last_o(b_last_o)
  );

  typedef struct packed { logic [31:0] d; logic l; } exp_t;
  typedef struct { logic [15:0] rows [4]; logic [15:0] o0; logic [15:0] o1; } vec_t;

  exp_t        q[$];
  logic [31:0] fr[$];
  int          total = 0;
  int          bad = 0;
  logic        hold_v = 1'b0;
  logic        hold_l;
  logic [31:0] hold_d;
  vec_t        tbl [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, expv);
    end
  endtask

  // Reference: each window is the plain max over its rows, per channel, then ReLU.
  task automatic model_frame(input int unsigned h, input int unsigned p, input int unsigned n,
                             input bit relu);
    int unsigned nwin = (h + p - 1) / p;
    for (int unsigned k = 0; k < nwin; k++) begin
      exp_t e;
      e.d = '0;
      e.l = (k == nwin - 1);
      for (int unsigned c = 0; c < n; c++) begin
        logic signed [15:0] best, v;
        logic [31:0] rr;
        best = 16'sh8000;
        for (int unsigned r = k * p; r < h && r < (k + 1) * p; r++) begin
          rr = fr[r];
          v = rr[c*16 +: 16];
          if (v > best) best = v;
        end
        if (relu && best < 0) best = 16'sd0;
        e.d[c*16 +: 16] = best;
      end
      q.push_back(e);
    end
  endtask

  task automatic step(input bit sel_b, input logic v, input logic [31:0] d, input logic r,
                      output logic fired, output logic ro, output logic vo);
    exp_t e;
    logic [31:0] dout;
    logic lout;
    string pre;
    pre = sel_b ? "b_" : "a_";
    @(negedge clk);
    a_valid = !sel_b && v;
    b_valid = sel_b && v;
    a_data  = d[15:0];
    b_data  = d;
    a_rdy   = sel_b ? 1'b1 : r;
    b_rdy   = sel_b ? r : 1'b1;
    #1;
    ro    = sel_b ? b_ready_o : a_ready_o;
    vo    = sel_b ? b_valid_o : a_valid_o;
    dout  = sel_b ? b_data_o : {16'h0, a_data_o};
    lout  = sel_b ? b_last_o : a_last_o;
    fired = v && ro;
    if (hold_v) begin
      check({pre, "hold_valid"}, 32'(vo), 32'd1);
      check({pre, "hold_data"}, dout, hold_d);
      check({pre, "hold_last"}, 32'(lout), 32'(hold_l));
    end
    hold_v = vo && !r;
    hold_d = dout;
    hold_l = lout;
    if (vo && r) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL %sunexpected_output: got=%h want=none", pre, dout);
      end else begin
        e = q.pop_front();
        check({pre, "out_data"}, dout, e.d);
        check({pre, "out_last"}, 32'(lout), 32'(e.l));
      end
    end
  endtask

  task automatic drive(input bit sel_b, input int unsigned pv, input int unsigned pr);
    logic f, ro, vo;
    logic [31:0] row;
    int unsigned budget;
    for (int unsigned i = 0; i < fr.size(); i++) begin
      row = fr[i];
      f = 1'b0;
      budget = 0;
      while (!f && budget < 200) begin
        step(sel_b, ($urandom_range(99) < pv), row, ($urandom_range(99) < pr), f, ro, vo);
        budget++;
      end
      if (!f) begin
        total++;
        bad++;
        $display("FAIL row_timeout: got=no_accept want=accept row=%0d", i);
      end
    end
  endtask

  task automatic drain(input bit sel_b);
    logic f, ro, vo;
    for (int unsigned i = 0; i < 30; i++) begin
      step(sel_b, 1'b0, '0, 1'b1, f, ro, vo);
      if (q.size() == 0 && !vo) break;
    end
    check("drain_empty", 32'(q.size()), 32'd0);
  endtask

  function automatic logic [15:0] rnd_word();
    case ($urandom_range(3))
      0:       return ($urandom_range(1) != 0) ? 16'h7FFF : 16'h8000;
      1:       return 16'($urandom_range(6)) - 16'd3;
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic exp_t mk(input logic [31:0] d, input logic l);
    exp_t e;
    e.d = d;
    e.l = l;
    return e;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got=running want=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic f, ro, vo;

    tbl[0] = '{'{16'h0003, 16'hFFF9, 16'h0005, 16'h0009}, 16'h0003, 16'h0009};
    tbl[1] = '{'{16'hFFFC, 16'hFFFE, 16'hFFFF, 16'hFFF8}, 16'h0000, 16'h0000};
    tbl[2] = '{'{16'h7FFF, 16'h8000, 16'h8000, 16'h8000}, 16'h7FFF, 16'h0000};
    tbl[3] = '{'{16'h0005, 16'h0005, 16'hFFFF, 16'h0064}, 16'h0005, 16'h0064};
    tbl[4] = '{'{16'h8000, 16'h0001, 16'h0002, 16'h0002}, 16'h0001, 16'h0002};

    reset_n = 1'b0;
    a_valid = 1'b0; a_rdy = 1'b1; a_data = '0;
    b_valid = 1'b0; b_rdy = 1'b1; b_data = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_a_valid", 32'(a_valid_o), 32'd0);
    check("rst_a_last", 32'(a_last_o), 32'd0);
    check("rst_a_data", {16'h0, a_data_o}, 32'd0);
    check("rst_a_ready", 32'(a_ready_o), 32'd1);
    check("rst_b_valid", 32'(b_valid_o), 32'd0);
    check("rst_b_data", b_data_o, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Table vectors on the default instance, full rate, with output timing.
    for (int unsigned t = 0; t < 5; t++) begin
      q.push_back(mk({16'h0, tbl[t].o0}, 1'b0));
      q.push_back(mk({16'h0, tbl[t].o1}, 1'b1));
      for (int unsigned k = 0; k < 4; k++) begin
        step(1'b0, 1'b1, {16'h0, tbl[t].rows[k]}, 1'b1, f, ro, vo);
        check("t1_accept", 32'(f), 32'd1);
        check("t1_valid_timing", 32'(vo), 32'(k == 2));
      end
      step(1'b0, 1'b0, '0, 1'b1, f, ro, vo);
      check("t1_valid_after_last", 32'(vo), 32'd1);
    end
    drain(1'b0);

    // Backpressure: closing row stalls while the output register is full.
    q.push_back(mk(32'd2, 1'b0));
    q.push_back(mk(32'd4, 1'b1));
    step(1'b0, 1'b1, 32'd1, 1'b1, f, ro, vo);  check("bp_acc0", 32'(f), 32'd1);
    step(1'b0, 1'b1, 32'd2, 1'b1, f, ro, vo);  check("bp_acc1", 32'(f), 32'd1);
    step(1'b0, 1'b1, 32'd3, 1'b0, f, ro, vo);  check("bp_ready_open", 32'(ro), 32'd1);
    check("bp_acc2", 32'(f), 32'd1);
    step(1'b0, 1'b1, 32'd4, 1'b0, f, ro, vo);  check("bp_ready_low", 32'(ro), 32'd0);
    step(1'b0, 1'b1, 32'd4, 1'b0, f, ro, vo);  check("bp_ready_low2", 32'(ro), 32'd0);
    check("bp_no_accept", 32'(f), 32'd0);
    step(1'b0, 1'b1, 32'd4, 1'b1, f, ro, vo);  check("bp_release", 32'(f), 32'd1);
    step(1'b0, 1'b0, '0, 1'b1, f, ro, vo);     check("bp_second_valid", 32'(vo), 32'd1);
    drain(1'b0);

    // Two channels, RELU off, partial final window, frames back to back.
    q.push_back(mk(32'h0005_0006, 1'b0));
    q.push_back(mk(32'hFFF9_FFFE, 1'b0));
    q.push_back(mk(32'h0008_0008, 1'b1));
    q.push_back(mk(32'h0000_0002, 1'b0));
    q.push_back(mk(32'h0000_0004, 1'b0));
    q.push_back(mk(32'h0000_0008, 1'b1));
    fr = '{32'h0005_FFFF, 32'hFFFD_0006, 32'hFFF9_FFFC, 32'hFFF7_FFFE, 32'h0008_0008};
    drive(1'b1, 100, 100);
    fr = '{32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 32'h0000_0004, 32'h0000_0008};
    drive(1'b1, 100, 100);
    drain(1'b1);

    for (int unsigned n = 0; n < 8; n++) begin
      fr.delete();
      for (int unsigned r = 0; r < 4; r++) fr.push_back({16'h0, rnd_word()});
      model_frame(4, 2, 1, 1'b1);
      drive(1'b0, $urandom_range(100, 40), $urandom_range(100, 40));
    end
    drain(1'b0);

    for (int unsigned n = 0; n < 8; n++) begin
      fr.delete();
      for (int unsigned r = 0; r < 5; r++) fr.push_back({rnd_word(), rnd_word()});
      model_frame(5, 2, 2, 1'b0);
      drive(1'b1, $urandom_range(100, 40), $urandom_range(100, 40));
    end
    drain(1'b1);

    // Asynchronous reset mid-window with a pending output.
    step(1'b0, 1'b1, 32'd10, 1'b0, f, ro, vo);
    step(1'b0, 1'b1, 32'd20, 1'b0, f, ro, vo);
    step(1'b0, 1'b1, 32'd30, 1'b0, f, ro, vo);
    check("ar_acc_mid", 32'(f), 32'd1);
    @(negedge clk);
    a_valid = 1'b0;
    #1;
    check("ar_pre_valid", 32'(a_valid_o), 32'd1);
    check("ar_pre_data", {16'h0, a_data_o}, 32'd20);
    #1;
    reset_n = 1'b0;
    #1;
    check("ar_valid", 32'(a_valid_o), 32'd0);
    check("ar_last", 32'(a_last_o), 32'd0);
    check("ar_data", {16'h0, a_data_o}, 32'd0);
    q.delete();
    hold_v = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    q.push_back(mk(32'd0, 1'b0));
    q.push_back(mk(32'd7, 1'b1));
    fr = '{32'h0000_FFFB, 32'h0000_FFFA, 32'h0000_0007, 32'h0000_0001};
    drive(1'b0, 100, 100);
    drain(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
